// File: rtl/mtc_pkg.sv
// Shared definitions for the MTC-to-SL link transmitter: word sizes, K-words,
// FSM state type and the CRC-8 (poly 0x07) step function.
package mtc_pkg;

   // Stand-in for the value normally provided by l0mdt_dataformats_svh.
   localparam int MTC2SL_LEN = 100;

   localparam logic [31:0] IDLE_WORD    = 32'hBCBC_BCBC;
   localparam logic [7:0]  SOF_K        = 8'h3C;
   localparam logic [7:0]  CRC8_POLY    = 8'h07;
   localparam int          CRC_WORD_MAX = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CRC     = 2'd2
   } tx_state_t;

   // Folds the low nbits of word into crc, MSB first; init/reflection handled by caller.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic [CRC_WORD_MAX-1:0] word,
                                            input int nbits);
      logic [7:0] c;
      logic       fb;
      c = crc;
      for (int i = CRC_WORD_MAX - 1; i >= 0; i--) begin
         if (i < nbits) begin
            fb = c[7] ^ word[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/mtc2sl_tx_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module mtc2sl_tx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // When full, wr_ptr == rd_ptr: the head is captured by the consumer on the
   // same edge that this slot is overwritten.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mtc2sl_link_tx.sv
// Frames buffered MTC2SL words as SOF + payload beats (+ CRC-8 beat when
// MTC2SL_TX_CRC_EN is defined) onto a LINK_W-bit link (LINK_W >= 32).
module mtc2sl_link_tx
   import mtc_pkg::*;
#(
   parameter int LINK_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int LINK_SLID  = 0
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [MTC2SL_LEN-1:0] mtc2sl,
   input  logic                  link_ready,
   output logic [LINK_W-1:0]     link_data,
   output logic                  link_k,
   output logic                  link_sop,
   output logic                  link_eop,
   output logic                  fifo_full,
   output logic                  overflow,
   output logic [15:0]           drop_cnt,
   output tx_state_t             dbg_state
);

   localparam int NUM_BEATS = (MTC2SL_LEN + LINK_W - 1) / LINK_W;
   localparam int SH_W      = NUM_BEATS * LINK_W;
   localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
   localparam int AW        = $clog2(FIFO_DEPTH);

   // Link handshake: a link word is transferred on every edge where link_ready=1;
   // with link_ready=0 the gearbox is stalled and all link_* outputs hold.

   logic                  in_valid;
   logic                  pop;
   logic                  drop;
   logic [MTC2SL_LEN-1:0] fifo_head;
   logic                  fifo_full_w;
   logic                  fifo_empty;
   logic [AW:0]           fifo_count;

   tx_state_t             state_q, state_n;
   logic [BEAT_W-1:0]     beat_q, beat_n;
   logic [SH_W-1:0]       shreg_q, shreg_n;
   logic [7:0]            seq_q, seq_n;
   logic [LINK_W-1:0]     data_n;
   logic                  k_n, sop_n, eop_n;
`ifdef MTC2SL_TX_CRC_EN
   logic [7:0]            crc_q, crc_n;
`endif

   assign in_valid  = mtc2sl[MTC2SL_LEN-1];
   assign drop      = in_valid && fifo_full_w && !pop;
   assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign dbg_state = state_q;

   mtc2sl_tx_fifo #(
      .W     (MTC2SL_LEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .din   (mtc2sl),
      .head  (fifo_head),
      .full  (fifo_full_w),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_n = state_q;
      beat_n  = beat_q;
      shreg_n = shreg_q;
      seq_n   = seq_q;
      data_n  = link_data;
      k_n     = link_k;
      sop_n   = link_sop;
      eop_n   = link_eop;
      pop     = 1'b0;
`ifdef MTC2SL_TX_CRC_EN
      crc_n   = crc_q;
`endif
      if (link_ready) begin
         sop_n = 1'b0;
         eop_n = 1'b0;
         case (state_q)
            ST_IDLE: begin
               k_n = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_n = SH_W'(fifo_head) << (SH_W - MTC2SL_LEN);
                  data_n  = LINK_W'({SOF_K, seq_q, 6'(LINK_SLID), 10'(NUM_BEATS)});
                  sop_n   = 1'b1;
                  seq_n   = seq_q + 8'd1;
                  beat_n  = '0;
                  state_n = ST_PAYLOAD;
`ifdef MTC2SL_TX_CRC_EN
                  crc_n   = 8'h00;
`endif
               end else begin
                  data_n = LINK_W'(IDLE_WORD);
               end
            end
            ST_PAYLOAD: begin
               data_n  = shreg_q[SH_W-1 -: LINK_W];
               shreg_n = shreg_q << LINK_W;
               k_n     = 1'b0;
               beat_n  = beat_q + BEAT_W'(1);
`ifdef MTC2SL_TX_CRC_EN
               crc_n   = crc8_step(crc_q, CRC_WORD_MAX'(shreg_q[SH_W-1 -: LINK_W]), LINK_W);
`endif
               if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
`ifdef MTC2SL_TX_CRC_EN
                  state_n = ST_CRC;
`else
                  eop_n   = 1'b1;
                  state_n = ST_IDLE;
`endif
               end
            end
            ST_CRC: begin
`ifdef MTC2SL_TX_CRC_EN
               data_n = LINK_W'(crc_q);
               k_n    = 1'b0;
               eop_n  = 1'b1;
`endif
               state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         shreg_q   <= '0;
         seq_q     <= 8'd0;
         link_data <= LINK_W'(IDLE_WORD);
         link_k    <= 1'b1;
         link_sop  <= 1'b0;
         link_eop  <= 1'b0;
`ifdef MTC2SL_TX_CRC_EN
         crc_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_n;
         beat_q    <= beat_n;
         shreg_q   <= shreg_n;
         seq_q     <= seq_n;
         link_data <= data_n;
         link_k    <= k_n;
         link_sop  <= sop_n;
         link_eop  <= eop_n;
`ifdef MTC2SL_TX_CRC_EN
         crc_q     <= crc_n;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= 16'd0;
      end else begin
         overflow <= drop;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_mtc2sl_link_tx.sv
// Bench for mtc2sl_link_tx: directed scenarios plus random traffic, checked every
// cycle against a frame-level queue model; honours MTC2SL_TX_CRC_EN.
module tb_mtc2sl_link_tx;
   import mtc_pkg::*;

   localparam int LEN   = MTC2SL_LEN;
   localparam int DEPTH = 4;
   localparam int NB    = (LEN + 31) / 32;
   localparam int PW    = NB * 32;
`ifdef MTC2SL_TX_CRC_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        k;
      logic        sop;
      logic        eop;
   } beat_t;

   logic            clock = 1'b0;
   logic            rst = 1'b1;
   logic [LEN-1:0]  mtc2sl = '0;
   logic            link_ready = 1'b1;
   logic [31:0]     link_data;
   logic            link_k, link_sop, link_eop, fifo_full, overflow;
   logic [15:0]     drop_cnt;
   tx_state_t       dbg_state;

   always #5 clock = ~clock;

   mtc2sl_link_tx #(.LINK_W(32), .FIFO_DEPTH(DEPTH), .LINK_SLID(0)) dut (
      .clock      (clock),
      .rst        (rst),
      .mtc2sl     (mtc2sl),
      .link_ready (link_ready),
      .link_data  (link_data),
      .link_k     (link_k),
      .link_sop   (link_sop),
      .link_eop   (link_eop),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .dbg_state  (dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [LEN-1:0] m_fifo[$];
   beat_t          m_frame[$];
   beat_t          e_out;
   logic           e_ovf;
   logic           e_full;
   logic [15:0]    e_drop;
   logic [7:0]     m_seq;

   int             sop_seen;
   logic [7:0]     last_seq;
   int             ovf_seen;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
   endtask

   function automatic logic [7:0] tb_crc_beat(input logic [7:0] crc, input logic [31:0] d);
      logic [7:0] c;
      logic       fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0};
         if (fb) c = c ^ 8'h07;
      end
      return c;
   endfunction

   function automatic void build_frame(input logic [LEN-1:0] w);
      logic [PW-1:0] p;
      logic [7:0]    crc;
      beat_t         b;
      p   = {w, {(PW - LEN){1'b0}}};
      crc = 8'h00;
      b   = '{data: {8'h3C, m_seq, 6'd0, 10'(NB)}, k: 1'b1, sop: 1'b1, eop: 1'b0};
      m_frame.push_back(b);
      m_seq = m_seq + 8'd1;
      for (int i = 0; i < NB; i++) begin
         b.data = p[PW-1-32*i -: 32];
         b.k    = 1'b0;
         b.sop  = 1'b0;
         b.eop  = (i == NB - 1) && !CRC_EN;
         crc    = tb_crc_beat(crc, b.data);
         m_frame.push_back(b);
      end
      if (CRC_EN) m_frame.push_back('{data: {24'h0, crc}, k: 1'b0, sop: 1'b0, eop: 1'b1});
   endfunction

   function automatic void model_step(input logic r, input logic [LEN-1:0] w, input logic rdy);
      int  n_before;
      bit  popped;
      if (r) begin
         m_fifo.delete();
         m_frame.delete();
         e_out  = '{data: IDLE_WORD, k: 1'b1, sop: 1'b0, eop: 1'b0};
         e_ovf  = 1'b0;
         e_full = 1'b0;
         e_drop = 16'd0;
         m_seq  = 8'd0;
         return;
      end
      n_before = m_fifo.size();
      popped   = 1'b0;
      if (rdy) begin
         if (m_frame.size() == 0 && n_before > 0) begin
            build_frame(m_fifo.pop_front());
            popped = 1'b1;
         end
         if (m_frame.size() > 0) e_out = m_frame.pop_front();
         else e_out = '{data: IDLE_WORD, k: 1'b1, sop: 1'b0, eop: 1'b0};
      end
      e_ovf = 1'b0;
      if (w[LEN-1]) begin
         if (n_before < DEPTH || popped) m_fifo.push_back(w);
         else begin
            e_ovf = 1'b1;
            if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
         end
      end
      e_full = (m_fifo.size() == DEPTH);
   endfunction

   task automatic compare();
      check("link", 64'({link_data, link_k, link_sop, link_eop}), 64'(e_out));
      check("stat", 64'({fifo_full, overflow, drop_cnt}), 64'({e_full, e_ovf, e_drop}));
      if (link_sop) begin
         sop_seen++;
         last_seq = link_data[23:16];
      end
      if (overflow) ovf_seen++;
   endtask

   task automatic step(input logic r, input logic v, input logic [LEN-1:0] w, input logic rdy);
      rst        = r;
      mtc2sl     = {v, w[LEN-2:0]};
      link_ready = rdy;
      model_step(r, mtc2sl, rdy);
      @(posedge clock);
      @(negedge clock);
      compare();
   endtask

   function automatic logic [LEN-1:0] rand_word();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[LEN-1:0];
   endfunction

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_word(), 1'b1);
   endtask

   task automatic reset_steps();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [LEN-1:0] w;
      logic [LEN-1:0] sent;

      // Pins on the bench's own CRC model
      check("crc_zero", 64'(tb_crc_beat(8'h00, 32'h0000_0000)), 64'h00);
      check("crc_one", 64'(tb_crc_beat(8'h00, 32'h0000_0001)), 64'h07);
      check("crc_0100", 64'(tb_crc_beat(8'h00, 32'h0000_0100)), 64'h15);

      reset_steps();
      check("rst_data", 64'(link_data), 64'hBCBC_BCBC);
      check("rst_k", 64'(link_k), 64'h1);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

      // Single word: SOF at second edge, beats MSB-first with zero padding
      w = rand_word();
      step(1'b0, 1'b1, w, 1'b1);
      sent = {1'b1, w[LEN-2:0]};
      check("single_idle", 64'(link_data), 64'hBCBC_BCBC);
      step(1'b0, 1'b0, '0, 1'b1);
      check("sof_lit", 64'({link_data, link_k, link_sop}), 64'({32'h3C00_0004, 1'b1, 1'b1}));
      step(1'b0, 1'b0, '0, 1'b1);
      check("beat0_lit", 64'(link_data), 64'(sent[99:68]));
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("pad_lit", 64'(link_data), 64'({sent[3:0], 28'h0}));
      check("eop_lit", 64'(link_eop), 64'(!CRC_EN));
      idle_steps(2);
      check("back_idle", 64'({link_data, link_k}), 64'({32'hBCBC_BCBC, 1'b1}));

      // Five consecutive words: no drops, five frames seq 0..4
      reset_steps();
      sop_seen = 0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand_word(), 1'b1);
      idle_steps(30);
      check("burst_frames", 64'(sop_seen), 64'd5);
      check("burst_seq", 64'(last_seq), 64'd4);
      check("burst_drop", 64'(drop_cnt), 64'd0);

      // Stall mid-payload while six words arrive
      step(1'b0, 1'b1, rand_word(), 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      ovf_seen = 0;
      for (int i = 0; i < 10; i++) step(1'b0, i < 6, rand_word(), 1'b0);
      check("stall_ovf", 64'(ovf_seen), 64'd2);
      check("stall_drop", 64'(drop_cnt), 64'd2);
      idle_steps(40);

      // Full FIFO with push coincident with pop
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_word(), 1'b0);
      check("fifo_full", 64'(fifo_full), 64'h1);
      step(1'b0, 1'b1, rand_word(), 1'b1);
      check("pushpop_ovf", 64'({fifo_full, overflow, link_sop}), 64'({1'b1, 1'b0, 1'b1}));
      idle_steps(40);

      // Reset in the middle of a frame
      step(1'b0, 1'b1, rand_word(), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      check("midrst_out", 64'({link_data, link_k, drop_cnt}), 64'({32'hBCBC_BCBC, 1'b1, 16'd0}));
      step(1'b0, 1'b1, rand_word(), 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("midrst_seq", 64'(link_data), 64'h3C00_0004);
      idle_steps(10);

      // Random traffic with random backpressure
      for (int i = 0; i < 800; i++)
         step(1'b0, 1'($urandom_range(0, 1)), rand_word(), $urandom_range(0, 3) != 0);
      idle_steps(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
